// File: rtl/eth_tx_rate_adapter.sv
// rtl/eth_tx_rate_adapter.sv - 10/100/1000 Ethernet TX rate adapter using symbol clock-enables
module eth_tx_rate_adapter #(
  parameter int           DIV_100       = 5,
  parameter int           DIV_10        = 50,
  parameter int           IFG_BYTES     = 12,
  parameter logic [1:0]   DEFAULT_SPEED = 2'b10
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       tx_ce,
  output logic       mii_clk,
  output logic [1:0] speed_active,
  output logic       busy
);

  localparam int CW = $clog2(DIV_10 + 1);
  localparam int IW = $clog2(2 * IFG_BYTES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_IFG  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_speed;
  logic          r_pend_hi;
  logic          r_last_seen;
  logic [3:0]    r_hi;
  logic [IW-1:0] r_ifg;

  logic          w_gmii;
  logic          w_ce;
  logic          w_need;
  logic          w_acc;
  logic          w_speed_ld;
  logic [CW-1:0] w_div_m1;
  logic [CW-1:0] w_half;
  logic [IW-1:0] w_ifg_m1;

  // 2'b10 and 2'b11 both mean 1000 Mb/s, so bit 1 alone selects byte mode
  assign w_gmii   = r_speed[1];
  assign w_div_m1 = (r_speed == 2'b01) ? CW'(DIV_100 - 1) : CW'(DIV_10 - 1);
  assign w_half   = (r_speed == 2'b01) ? CW'(DIV_100 / 2) : CW'(DIV_10 / 2);
  assign w_ce     = w_gmii | (r_cnt == w_div_m1);
  assign w_need   = w_gmii | ~r_pend_hi;
  assign w_ifg_m1 = w_gmii ? IW'(IFG_BYTES - 1) : IW'(2 * IFG_BYTES - 1);
  assign w_acc    = s_valid & s_ready;
  // a rate change is only taken between frames, never on the edge that starts one
  assign w_speed_ld = (r_state == S_IDLE) && !w_acc && (speed != r_speed);

  assign tx_ce        = w_ce;
  assign mii_clk      = !w_gmii && (r_cnt >= w_half);
  assign speed_active = r_speed;
  assign busy         = (r_state != S_IDLE);

  // input handshake depends only on state, nibble phase and the symbol strobe
  always_comb begin
    s_ready = 1'b0;
    case (r_state)
      S_IDLE:  s_ready = w_ce;
      S_SEND:  s_ready = w_ce && w_need && !r_last_seen;
      S_DROP:  s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // symbol divider; held at 0 in byte mode and restarted on a rate change
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_speed_ld || w_gmii || (r_cnt == w_div_m1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // rate in force, loaded from the request only while idle
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_speed <= DEFAULT_SPEED;
    end else if (w_speed_ld) begin
      r_speed <= speed;
    end
  end

  // frame FSM and registered GMII/MII outputs, advanced on symbol strobes
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      txd         <= '0;
      tx_en       <= 1'b0;
      tx_er       <= 1'b0;
      r_pend_hi   <= 1'b0;
      r_last_seen <= 1'b0;
      r_hi        <= '0;
      r_ifg       <= '0;
    end else if (w_ce) begin
      txd   <= '0;
      tx_en <= 1'b0;
      tx_er <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            txd         <= w_gmii ? s_data : {4'b0000, s_data[3:0]};
            tx_en       <= 1'b1;
            r_hi        <= s_data[7:4];
            r_pend_hi   <= !w_gmii;
            r_last_seen <= s_last;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_need && !r_last_seen) begin
            if (s_valid) begin
              txd         <= w_gmii ? s_data : {4'b0000, s_data[3:0]};
              tx_en       <= 1'b1;
              r_hi        <= s_data[7:4];
              r_pend_hi   <= !w_gmii;
              r_last_seen <= s_last;
            end else begin
              // underrun: one error symbol, then discard the rest of the frame
              tx_en   <= 1'b1;
              tx_er   <= 1'b1;
              r_state <= S_DROP;
            end
          end else if (r_pend_hi) begin
            txd       <= {4'b0000, r_hi};
            tx_en     <= 1'b1;
            r_pend_hi <= 1'b0;
          end else begin
            // this strobe drops tx_en and is the first symbol of the gap
            r_ifg   <= IW'(1);
            r_state <= S_IFG;
          end
        end
        S_DROP: begin
          if (s_valid && s_last) begin
            r_ifg   <= IW'(1);
            r_state <= S_IFG;
          end
        end
        default: begin
          // leave one symbol early so the next frame can start on the strobe that ends the gap
          if (r_ifg == w_ifg_m1) begin
            r_state <= S_IDLE;
          end else begin
            r_ifg <= r_ifg + IW'(1);
          end
        end
      endcase
    end else if ((r_state == S_DROP) && s_valid && s_last) begin
      // frame end seen between MII strobes: gap counting starts at the next strobe
      r_ifg   <= '0;
      r_state <= S_IFG;
    end
  end

endmodule

// File: tb/tb_eth_tx_rate_adapter.sv
// tb/tb_eth_tx_rate_adapter.sv - directed self-checking bench for eth_tx_rate_adapter
module tb_eth_tx_rate_adapter;

  logic       sys_clk;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       tx_ce;
  logic       mii_clk;
  logic [1:0] speed_active;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  eth_tx_rate_adapter dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .speed        (speed),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .txd          (txd),
    .tx_en        (tx_en),
    .tx_er        (tx_er),
    .tx_ce        (tx_ce),
    .mii_clk      (mii_clk),
    .speed_active (speed_active),
    .busy         (busy)
  );

  initial sys_clk = 1'b0;
  always #4 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int ce_cnt;
    logic [4:0] pat;
    logic [7:0] nib [4];
    logic [7:0] exp_b;

    nib[0] = 8'h0C; nib[1] = 8'h03; nib[2] = 8'h06; nib[3] = 8'h09;

    // reset state
    rst = 1'b1; speed = 2'b10; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    chk("rst_txd", txd, 8'h00);
    chk("rst_en", tx_en, 1'b0);
    chk("rst_er", tx_er, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_speed", speed_active, 2'b10);
    chk("rst_mii_clk", mii_clk, 1'b0);
    chk("rst_tx_ce_1000", tx_ce, 1'b1);
    rst = 1'b0;
    tick();

    // GMII 3-byte frame 55 D5 AB, then 12-symbol gap
    s_data = 8'h55; s_valid = 1'b1;
    chk("g_ready_idle", s_ready, 1'b1);
    tick();
    chk("g_b0", {tx_en, txd}, {1'b1, 8'h55});
    s_data = 8'hD5;
    tick();
    chk("g_b1", {tx_en, txd}, {1'b1, 8'hD5});
    s_data = 8'hAB; s_last = 1'b1;
    tick();
    chk("g_b2", {tx_en, txd}, {1'b1, 8'hAB});
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    chk("g_en_off", tx_en, 1'b0);
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      if (tx_en !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) bad++;
      tick();
    end
    chk("g_ifg_span", bad, 0);
    chk("g_ifg_done", busy, 1'b0);

    // 100 Mb/s single-byte frame A5
    speed = 2'b01;
    tick();
    chk("m_speed", speed_active, 2'b01);
    chk("m_ce_cnt0", {tx_ce, s_ready}, 2'b00);
    s_data = 8'hA5; s_valid = 1'b1; s_last = 1'b1;
    pat = {4'b0000, mii_clk};
    for (int i = 0; i < 4; i++) begin
      tick();
      pat = {pat[3:0], mii_clk};
    end
    chk("m_mii_clk_pattern", pat, 5'b00111);
    chk("m_ce_ready", {tx_ce, s_ready}, 2'b11);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      exp_b = (i < 5) ? 8'h05 : 8'h0A;
      if (txd !== exp_b || tx_en !== 1'b1) bad++;
      tick();
    end
    chk("m_nibbles", bad, 0);
    chk("m_en_off", tx_en, 1'b0);
    bad = 0;
    for (int i = 0; i < 115; i++) begin
      if (tx_en !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    chk("m_ifg_span", bad, 0);
    chk("m_ifg_done", busy, 1'b0);

    // 10 Mb/s 2-byte frame 3C 96
    speed = 2'b00;
    tick();
    chk("t_speed", speed_active, 2'b00);
    s_data = 8'h3C; s_valid = 1'b1; s_last = 1'b0;
    n = 0;
    while (tx_ce !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t_first_ce", n, 49);
    tick();
    s_data = 8'h96; s_last = 1'b1;
    bad = 0; ce_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== nib[i / 50] || tx_en !== 1'b1) bad++;
      if (tx_ce === 1'b1) ce_cnt++;
      if (i == 100) begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      tick();
    end
    chk("t_nibbles_200", bad, 0);
    chk("t_ce_count", ce_cnt, 4);
    chk("t_en_off", tx_en, 1'b0);
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("t_idle", busy, 1'b0);

    // GMII underrun after 2 of 5 bytes
    speed = 2'b10;
    tick();
    chk("u_speed", speed_active, 2'b10);
    s_data = 8'h11; s_valid = 1'b1;
    tick();
    s_data = 8'h22;
    tick();
    chk("u_b1", {tx_en, txd}, {1'b1, 8'h22});
    s_valid = 1'b0;
    tick();
    chk("u_err_sym", {tx_en, tx_er, txd}, {1'b1, 1'b1, 8'h00});
    chk("u_drop_ready", s_ready, 1'b1);
    s_data = 8'h33; s_valid = 1'b1;
    tick();
    chk("u_drop_out", {tx_en, tx_er, busy}, 3'b001);
    s_data = 8'h44;
    tick();
    s_data = 8'h55; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      if (tx_en !== 1'b0 || tx_er !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    chk("u_ifg_span", bad, 0);
    chk("u_ifg_done", busy, 1'b0);

    // speed change requested mid-frame is deferred to IDLE
    s_data = 8'hC1; s_valid = 1'b1;
    tick();
    speed = 2'b01;
    s_data = 8'hC2;
    tick();
    s_data = 8'hC3; s_last = 1'b1;
    tick();
    chk("s_b2_at_1000", {tx_en, txd, speed_active}, {1'b1, 8'hC3, 2'b10});
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) tick();
    chk("s_idle_old_speed", {busy, speed_active}, {1'b0, 2'b10});
    tick();
    chk("s_new_speed", speed_active, 2'b01);
    s_data = 8'h7E; s_valid = 1'b1; s_last = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("s_ready_mii", s_ready, 1'b1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("s_lo_nib", {tx_en, txd}, {1'b1, 8'h0E});
    for (int i = 0; i < 5; i++) tick();
    chk("s_hi_nib", {tx_en, txd}, {1'b1, 8'h07});
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    chk("s_idle", busy, 1'b0);

    // reset in the middle of an MII frame
    s_data = 8'h5A; s_valid = 1'b1; s_last = 1'b0;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    s_data = 8'h11;
    tick(); tick(); tick();
    chk("r_midframe_en", tx_en, 1'b1);
    rst = 1'b1;
    tick();
    chk("r_outputs", {tx_en, tx_er, txd, busy, mii_clk}, 12'h000);
    chk("r_speed_default", speed_active, 2'b10);
    rst = 1'b0; s_valid = 1'b0;
    chk("r_speed_after_release", speed_active, 2'b10);
    tick();
    chk("r_speed_reload", speed_active, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_tx_rate_adapter.md
# eth_tx_rate_adapter

Runtime-selectable 10/100/1000 Mb/s Ethernet transmit rate adapter on the single 125 MHz `sys_clk`. It accepts a byte stream from the MAC framer and drives GMII bytes or MII nibbles using symbol clock-enables instead of derived clocks. It also produces the MII-rate `mii_clk` level output, enforces the inter-frame gap, and flags underruns with `tx_er`. It replaces the fixed-mode TX clock generator. The GMII `gtx_clk` stays external as `~sys_clk`.

## Interface
- `DIV_100`, 5: `sys_clk` cycles per MII symbol at 100 Mb/s (25 MHz).
- `DIV_10`, 50: `sys_clk` cycles per MII symbol at 10 Mb/s (2.5 MHz).
- `IFG_BYTES`, 12: minimum inter-frame gap in byte times.
- `DEFAULT_SPEED`, 2'b10: `speed_active` value after reset.

Ports:
- `sys_clk`  in  1  125 MHz clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `speed`  in  2  requested rate: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 = 1000.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  last byte of frame, qualified by `s_valid`.
- `s_ready`  out  1  byte consumed when `s_valid && s_ready`.
- `txd`  out  8  GMII byte; MII nibble on [3:0] with [7:4] = 0.
- `tx_en`  out  1  transmit enable.
- `tx_er`  out  1  transmit error.
- `tx_ce`  out  1  symbol strobe, one `sys_clk` cycle wide.
- `mii_clk`  out  1  MII-rate clock level; constant 0 in 1000 mode.
- `speed_active`  out  2  rate currently in force.
- `busy`  out  1  state is not IDLE.

## Operation
**Divider**
- Counter `cnt` runs 0..DIV-1, with DIV = `DIV_100` or `DIV_10` per `speed_active`.
- `tx_ce` is 1 when `cnt == DIV-1`.
- In 1000 mode `tx_ce` is 1 every cycle.
- `mii_clk` is 0 while `cnt < DIV/2` (integer division) and 1 otherwise. The rising edge therefore falls mid-symbol.

**Speed change**
- `speed_active` loads `speed` only in IDLE.
- On a value change, `cnt` is cleared to 0 on the same edge.
- Changes requested mid-frame are held off until IDLE.

**State machine**
- IDLE
  - `s_ready = tx_ce`.
  - On accept: go to SEND.
- SEND
  - Byte modes: `s_ready = tx_ce && need_byte && !last_seen`.
  - GMII: `need_byte` is 1 on every symbol.
  - MII: the accepted byte drives the low nibble on that symbol. The high nibble drives the next symbol. `need_byte` is 1 only after the high nibble has been issued.
  - Underrun: at a `tx_ce` with `need_byte`, `!last_seen` and `!s_valid`, drive `tx_en=1`, `tx_er=1`, `txd=0` for that one symbol, then go to DROP.
  - End of frame: after the final symbol of the `s_last` byte, the next `tx_ce` drives `tx_en=0` and goes to IFG.
- DROP
  - `s_ready=1` every cycle; `tx_en=0`.
  - Accepted bytes are discarded.
  - On `s_valid && s_last` accepted: go to IFG.
- IFG
  - `s_ready=0`; `tx_en=0`.
  - Counts `IFG_BYTES` symbols in GMII mode and `2*IFG_BYTES` symbols in MII mode. Counting starts at the `tx_ce` that deasserted `tx_en`.
  - When the count is done: go to IDLE.

**Outputs**
- `txd`, `tx_en` and `tx_er` are registered.
- They update only on `tx_ce` edges, except on reset.

## Timing
- Reset values: `txd=0`, `tx_en=0`, `tx_er=0`, `cnt=0`, `speed_active=DEFAULT_SPEED`, state IDLE, `busy=0`.
- `tx_ce`, `mii_clk` and `s_ready` are combinational from state and `cnt`, so they are also 0 in reset, since `cnt=0`. Exception: `tx_ce` is 1 in 1000 mode.
- Latency: a byte accepted on cycle t appears on `txd` at t+1 in GMII mode. In MII mode the low nibble appears at t+1 and the high nibble at t+1+DIV.
- The first byte of a frame is accepted only on a `tx_ce` cycle.
- Back-to-back GMII frame: `tx_en` is high for exactly N cycles for N bytes. Gap between frames is at least 12 cycles with `tx_en=0`.
- Reset mid-frame: `tx_en` is 0 on the next edge, with no `tx_er` pulse. The input side is not drained.
- `s_valid` falling during IFG or DROP has no effect.
- A single-byte frame (`s_last` on first byte) is legal.

## Test plan
- GMII, 3-byte frame 0x55, 0xD5, 0xAB with `s_valid` held -> `txd` = 55, D5, AB on 3 consecutive cycles with `tx_en=1` -> `tx_en=0` for 12 cycles -> `busy=0`.
- 100 Mb/s, byte 0xA5 with `s_last` -> `txd` = 0x5 for 5 cycles, then 0xA for 5 cycles -> `tx_en=0` for 120 cycles; `mii_clk` is 0 for 2 cycles and 1 for 3 cycles in each symbol.
- 10 Mb/s, 2-byte frame -> `tx_ce` period is 50 cycles; `tx_en` high for 200 cycles.
- GMII underrun: `s_valid=0` after byte 2 of 5 -> one cycle with `tx_en=1`, `tx_er=1`, `txd=0` -> DROP accepts the remaining bytes up to `s_last` -> 12-cycle IFG.
- `speed` changed from 1000 to 100 mid-frame -> frame completes at 1000 -> `speed_active=2'b01` in IDLE -> next frame is sent as nibbles.
- `rst` asserted in the middle of a MII frame -> all outputs 0 next cycle; `speed_active=2'b10` (DEFAULT_SPEED) on the cycle after `rst` deasserts.
